// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster timing output bundle from video_timing_gen
// Purpose: groups the sync / data-enable / coordinate outputs of the timing
//          generator so the HDMI transmitter and frame-buffer reader share one port.
// Signals: hs, vs          sync outputs (polarity set by the generator)
//          de              data enable, high on active pixels
//          pix_x, pix_y    active coordinate, 0 when de is low
//          pix_req         early pixel fetch strobe for the frame-buffer reader
//          frame_start     one-cycle pulse with the de cycle at (0,0)
//          running         generator is producing raster
// Modports: master = generator side, slave = consumer side.
interface video_timing_gen_if;
  logic        hs;
  logic        vs;
  logic        de;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        pix_req;
  logic        frame_start;
  logic        running;

  modport master (
    output hs, vs, de, pix_x, pix_y, pix_req, frame_start, running
  );

  modport slave (
    input hs, vs, de, pix_x, pix_y, pix_req, frame_start, running
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - PLL-gated raster timing generator (default 1280x720p60)
// Purpose: waits for the video PLL to report lock for LOCK_WAIT clocks, then
//          free-runs horizontal/vertical counters and decodes HDMI sync,
//          data enable, pixel coordinates and an early pixel-request strobe.
// Ports:   clk         pixel clock (PLL outclk_0)
//          rst_n       synchronous active-low reset
//          pll_locked  PLL locked, asynchronous to clk
//          vid         video_timing_gen_if.master outputs, all registered
module video_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int REQ_LEAD  = 2,
  parameter int LOCK_WAIT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_locked,
  video_timing_gen_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = $clog2(LOCK_WAIT + 1);

  localparam logic [11:0] C_H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] C_HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] C_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] C_H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] C_V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] C_VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] C_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] C_V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [12:0] C_LEAD     = 13'(REQ_LEAD);
  localparam logic [12:0] C_H_TOT13  = 13'(H_TOTAL);
  localparam logic [12:0] C_H_ACT13  = 13'(H_ACTIVE);
  localparam logic [SW-1:0] C_SETTLE_LAST = SW'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t        r_state;
  logic          r_lock_meta;
  logic          r_lock_s;
  logic [SW-1:0] r_settle_cnt;
  logic [11:0]   r_h_cnt;
  logic [11:0]   r_v_cnt;
  logic          r_hs;
  logic          r_vs;
  logic          r_de;
  logic [11:0]   r_pix_x;
  logic [11:0]   r_pix_y;
  logic          r_pix_req;
  logic          r_frame_start;
  logic          r_running;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_de;
  logic          w_hs_act;
  logic          w_vs_act;
  logic [12:0]   w_la_sum;
  logic [12:0]   w_la_wrap;
  logic          w_la_carry;
  logic [12:0]   w_la_h;
  logic [11:0]   w_la_v;
  logic          w_req;

  assign w_h_last = (r_h_cnt == C_H_LAST);
  assign w_v_last = (r_v_cnt == C_V_LAST);
  assign w_de     = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
  assign w_hs_act = (r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END);
  // vs decodes v_cnt only, so its edges land on the h_cnt=0 decode.
  assign w_vs_act = (r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END);

  // Lookahead position REQ_LEAD clocks ahead; REQ_LEAD < H_TOTAL, so at most
  // one line carry is possible, and the line carry wraps the frame as well.
  assign w_la_sum   = {1'b0, r_h_cnt} + C_LEAD;
  assign w_la_carry = (w_la_sum >= C_H_TOT13);
  assign w_la_wrap  = w_la_sum - C_H_TOT13;
  assign w_la_h     = w_la_carry ? w_la_wrap : w_la_sum;
  assign w_la_v     = !w_la_carry ? r_v_cnt :
                      (w_v_last ? 12'd0 : r_v_cnt + 12'd1);
  assign w_req      = (w_la_h < C_H_ACT13) && (w_la_v < C_V_ACT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_WAIT_LOCK;
      r_lock_meta   <= 1'b0;
      r_lock_s      <= 1'b0;
      r_settle_cnt  <= '0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_de          <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_req     <= 1'b0;
      r_frame_start <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;

      // Idle output values; only a RUN cycle with lock still present
      // overrides them, so losing lock blanks everything on one edge.
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_de          <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_req     <= 1'b0;
      r_frame_start <= 1'b0;
      r_running     <= 1'b0;

      case (r_state)
        ST_WAIT_LOCK: begin
          r_settle_cnt <= '0;
          if (r_lock_s) begin
            r_state <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (!r_lock_s) begin
            r_state <= ST_WAIT_LOCK;
          end else if (r_settle_cnt == C_SETTLE_LAST) begin
            r_state   <= ST_RUN;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_running <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
          end
        end

        ST_RUN: begin
          if (!r_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
          end else begin
            r_running     <= 1'b1;
            r_de          <= w_de;
            r_hs          <= w_hs_act ? HS_POL : ~HS_POL;
            r_vs          <= w_vs_act ? VS_POL : ~VS_POL;
            r_pix_x       <= w_de ? r_h_cnt : 12'd0;
            r_pix_y       <= w_de ? r_v_cnt : 12'd0;
            r_pix_req     <= w_req;
            r_frame_start <= w_de && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
            if (w_h_last) begin
              r_h_cnt <= '0;
              r_v_cnt <= w_v_last ? 12'd0 : r_v_cnt + 12'd1;
            end else begin
              r_h_cnt <= r_h_cnt + 12'd1;
            end
          end
        end

        default: r_state <= ST_WAIT_LOCK;
      endcase
    end
  end

  assign vid.hs          = r_hs;
  assign vid.vs          = r_vs;
  assign vid.de          = r_de;
  assign vid.pix_x       = r_pix_x;
  assign vid.pix_y       = r_pix_y;
  assign vid.pix_req     = r_pix_req;
  assign vid.frame_start = r_frame_start;
  assign vid.running     = r_running;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen on a reduced raster
module tb_video_timing_gen;
  localparam int HA  = 16;
  localparam int HFP = 4;
  localparam int HSW = 3;
  localparam int HBP = 5;
  localparam int VA  = 6;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int RL  = 2;
  localparam int LW  = 16;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b0;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FR  = HT * VT;
  localparam int WIN = 2 * FR + HT;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  pix_t sb[$];

  video_timing_gen_if vid ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HP), .VS_POL(VP), .REQ_LEAD(RL), .LOCK_WAIT(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .vid(vid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] obs_vec();
    return {vid.hs, vid.vs, vid.de, vid.pix_req, vid.frame_start, vid.running,
            vid.pix_x, vid.pix_y};
  endfunction

  function automatic logic [29:0] idle_vec();
    return {~HP, ~VP, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};
  endfunction

  // Called right after the last input change (lock rise or reset release);
  // the next clock edge is the first to sample pll_locked high.
  task automatic expect_start(input string tag);
    pix_t e;
    step(LW + 2);
    n_tests++;
    if (vid.running !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_running_early: got %b want 0", tag, vid.running);
    end
    step(1);
    n_tests++;
    if ({vid.running, vid.de} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s_running_rise: running/de got %b%b want 10", tag, vid.running, vid.de);
    end
    step(1);
    n_tests++;
    if ({vid.de, vid.frame_start, vid.pix_x, vid.pix_y} !== {1'b1, 1'b1, 24'd0}) begin
      n_fail++;
      $display("FAIL %s_first_pixel: de=%b fs=%b x=%0d y=%0d want 1 1 0 0",
               tag, vid.de, vid.frame_start, vid.pix_x, vid.pix_y);
    end
    for (int x = 0; x < HA; x++) sb.push_back('{x: 12'(x), y: 12'd0, fs: (x == 0)});
    for (int i = 0; i < HA; i++) begin
      if (i > 0) step(1);
      e = sb.pop_front();
      n_tests++;
      if ({vid.de, vid.pix_x, vid.pix_y, vid.frame_start} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL %s_line0_px%0d: de=%b x=%0d y=%0d fs=%b want 1 %0d %0d %b",
                 tag, i, vid.de, vid.pix_x, vid.pix_y, vid.frame_start, e.x, e.y, e.fs);
      end
    end
  endtask

  task automatic wait_pix(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      if (vid.de === 1'b1 && vid.pix_x == 12'(x) && vid.pix_y == 12'(y)) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_tests++;
      if (obs_vec() !== idle_vec()) begin
        n_fail++;
        $display("FAIL reset_state_c%0d: got %h want %h", i, obs_vec(), idle_vec());
      end
    end
  endtask

  task automatic test_startup();
    pll_locked = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(4);
    n_tests++;
    if (obs_vec() !== idle_vec()) begin
      n_fail++;
      $display("FAIL unlocked_idle: got %h want %h", obs_vec(), idle_vec());
    end
    pll_locked = 1'b1;
    expect_start("startup");
  endtask

  task automatic test_frames();
    bit   found;
    pix_t e;
    int   idle_bad, bad, cnt;
    logic p_de, p_hs, p_vs;
    int   de_r[$], de_f[$], hs_r[$], hs_f[$], vs_r[$], vs_f[$], fs_q[$];
    logic req_h[$], de_h[$];

    found = 1'b0;
    for (int i = 0; i < FR + 10; i++) begin
      if (vid.frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL frame_start_timeout: got none want pulse within %0d cycles", FR + 10);
      return;
    end

    for (int f = 0; f < 3; f++)
      for (int y = 0; y < ((f == 2) ? 1 : VA); y++)
        for (int x = 0; x < HA; x++)
          sb.push_back('{x: 12'(x), y: 12'(y), fs: (x == 0 && y == 0)});

    idle_bad = 0;
    p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      if (i > 0) step(1);
      if (vid.de === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow_c%0d: got extra de cycle want none", i);
        end else begin
          e = sb.pop_front();
          if ({vid.pix_x, vid.pix_y, vid.frame_start} !== e) begin
            n_fail++;
            $display("FAIL pixel_c%0d: x=%0d y=%0d fs=%b want %0d %0d %b",
                     i, vid.pix_x, vid.pix_y, vid.frame_start, e.x, e.y, e.fs);
          end
        end
      end else if (vid.pix_x !== 12'd0 || vid.pix_y !== 12'd0 || vid.frame_start !== 1'b0) begin
        idle_bad++;
      end
      if (vid.de === 1'b1 && !p_de) de_r.push_back(i);
      if (vid.de !== 1'b1 && p_de)  de_f.push_back(i);
      if (vid.hs === HP && !p_hs)   hs_r.push_back(i);
      if (vid.hs !== HP && p_hs)    hs_f.push_back(i);
      if (vid.vs === VP && !p_vs)   vs_r.push_back(i);
      if (vid.vs !== VP && p_vs)    vs_f.push_back(i);
      if (vid.frame_start === 1'b1) fs_q.push_back(i);
      p_de = (vid.de === 1'b1);
      p_hs = (vid.hs === HP);
      p_vs = (vid.vs === VP);
      req_h.push_back(vid.pix_req);
      de_h.push_back(vid.de);
    end

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d unconsumed want 0", sb.size());
    end
    n_tests++;
    if (idle_bad != 0) begin
      n_fail++;
      $display("FAIL blank_coords_zero: got %0d bad cycles want 0", idle_bad);
    end

    n_tests++;
    if (fs_q.size() != 3 || fs_q[0] != 0 || fs_q[1] != FR || fs_q[2] != 2 * FR) begin
      n_fail++;
      $display("FAIL frame_start_period: got %0d pulses (2nd at %0d) want 3 at period %0d",
               fs_q.size(), (fs_q.size() > 1) ? fs_q[1] : -1, FR);
    end

    bad = 0;
    if (de_r.size() != 2 * VA + 1 || de_f.size() != 2 * VA + 1) bad++;
    else
      for (int k = 0; k < de_r.size(); k++)
        if (de_r[k] != (k / VA) * FR + (k % VA) * HT || de_f[k] - de_r[k] != HA) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL de_lines: got %0d rises / %0d bad want %0d rises, width %0d",
               de_r.size(), bad, 2 * VA + 1, HA);
    end

    bad = 0;
    if (hs_r.size() != 2 * VT + 1 || hs_f.size() != 2 * VT + 1) bad++;
    else
      for (int k = 0; k < hs_r.size(); k++)
        if (hs_r[k] != k * HT + HA + HFP || hs_f[k] - hs_r[k] != HSW) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hs_timing: got %0d rises / %0d bad want %0d, period %0d width %0d",
               hs_r.size(), bad, 2 * VT + 1, HT, HSW);
    end
    n_tests++;
    if (hs_r.size() == 0 || de_r.size() == 0 || hs_r[0] - de_r[0] != HA + HFP) begin
      n_fail++;
      $display("FAIL hs_lead_from_de: got %0d want %0d",
               (hs_r.size() > 0 && de_r.size() > 0) ? hs_r[0] - de_r[0] : -1, HA + HFP);
    end

    n_tests++;
    if (vs_r.size() != 2 || vs_f.size() != 2 ||
        vs_r[0] != (VA + VFP) * HT || vs_r[1] != FR + (VA + VFP) * HT ||
        vs_f[0] - vs_r[0] != VSW * HT || vs_f[1] - vs_r[1] != VSW * HT) begin
      n_fail++;
      $display("FAIL vs_timing: got %0d pulses first at %0d want 2 at %0d width %0d",
               vs_r.size(), (vs_r.size() > 0) ? vs_r[0] : -1, (VA + VFP) * HT, VSW * HT);
    end

    bad = 0;
    for (int i = 0; i + RL < WIN; i++)
      if (req_h[i] !== de_h[i + RL]) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pix_req_lead: got %0d cycles not matching de %0d later want 0", bad, RL);
    end
    n_tests++;
    if (req_h[FR - RL] !== 1'b1 || req_h[FR - RL - 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL pix_req_first_of_frame: got %b%b at line %0d h %0d-%0d want 01",
               req_h[FR - RL - 1], req_h[FR - RL], VT - 1, HT - RL - 1, HT - RL);
    end
    cnt = 0;
    for (int i = FR - RL; i < 2 * FR - RL; i++)
      if (req_h[i] === 1'b1) cnt++;
    n_tests++;
    if (cnt != VA * HA) begin
      n_fail++;
      $display("FAIL pix_req_count: got %0d want %0d", cnt, VA * HA);
    end
  endtask

  task automatic test_lock_drop();
    bit ok;
    wait_pix(10, 2, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL lockdrop_wait_pos: got no (10,2) want reached");
    end
    pll_locked = 1'b0;
    step(3);
    n_tests++;
    if (obs_vec() !== idle_vec()) begin
      n_fail++;
      $display("FAIL lockdrop_blank: got %h want %h", obs_vec(), idle_vec());
    end
    step(5);
    n_tests++;
    if (obs_vec() !== idle_vec()) begin
      n_fail++;
      $display("FAIL lockdrop_hold: got %h want %h", obs_vec(), idle_vec());
    end
    pll_locked = 1'b1;
    expect_start("relock");
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_pix(10, 2, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstmid_wait_pos: got no (10,2) want reached");
    end
    rst_n = 1'b0;
    step(1);
    n_tests++;
    if (obs_vec() !== idle_vec()) begin
      n_fail++;
      $display("FAIL rstmid_blank: got %h want %h", obs_vec(), idle_vec());
    end
    rst_n = 1'b1;
    expect_start("rst_restart");
  endtask

  initial begin
    test_reset();
    test_startup();
    test_frames();
    test_lock_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator that sits directly downstream of the video PLL.
- Runs on the PLL's 74.25 MHz outclk and is gated by the PLL `locked` output.
- Produces HDMI transmitter sync, data-enable and pixel coordinates, plus an early pixel-request strobe for the upstream frame-buffer reader.
- Defaults are CEA 1280x720p60.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- REQ_LEAD, 2, cycles pix_req leads de; legal range 0..(H_FP+H_SYNC+H_BP-1)
- LOCK_WAIT, 1024, clocks `locked` must stay high before raster starts; must be ≥1

Ports:
- clk  in  1  pixel clock (PLL outclk_0)
- rst_n  in  1  synchronous active-low reset
- pll_locked  in  1  PLL locked; asynchronous to clk
- hs  out  1  horizontal sync, polarity HS_POL
- vs  out  1  vertical sync, polarity VS_POL
- de  out  1  data enable, high during active pixels
- pix_x  out  12  active column; 0 when de low
- pix_y  out  12  active row; 0 when de low
- pix_req  out  1  pixel fetch strobe, REQ_LEAD cycles ahead of de
- frame_start  out  1  one-cycle pulse coincident with the de cycle at (0,0)
- running  out  1  high while in RUN state

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the following values:
  - hs=~HS_POL, vs=~VS_POL.
  - de, pix_req, frame_start, running = 0; pix_x, pix_y = 0.
  - State = WAIT_LOCK, counters cleared, sync flops cleared.
- pll_locked passes through a 2-flop synchronizer; locked_s is the synchronized value.
- State machine:
  - WAIT_LOCK: go to SETTLE when locked_s=1; clear settle counter.
  - SETTLE: increment settle counter each cycle. If locked_s=0, return to WAIT_LOCK. When the counter reaches LOCK_WAIT-1, go to RUN with h_cnt=0, v_cnt=0.
  - RUN: counters advance. If locked_s=0, go to WAIT_LOCK on the next edge; all outputs return to reset values on that same edge (no partial-line completion).
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1650; V_TOTAL = 750.
  - h_cnt wraps at H_TOTAL-1 to 0 and increments v_cnt.
  - v_cnt wraps at V_TOTAL-1 to 0.
- All outputs are registered, one cycle after the counter value they decode:
  - de = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs active for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs active for whole lines V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. vs edges coincide with h_cnt=0 decode.
  - pix_x=h_cnt and pix_y=v_cnt when de, else 0.
  - frame_start = de && h_cnt==0 && v_cnt==0.
- pix_req:
  - High exactly REQ_LEAD cycles before each de-high cycle; exactly H_ACTIVE pulses-cycles per active line, contiguous.
  - Decoded from a lookahead position (h_cnt+REQ_LEAD, carrying into v_cnt and wrapping V_TOTAL-1 to 0).
  - The frame's first request therefore falls in the last vertical back-porch line.
  - REQ_LEAD=0 makes pix_req identical to de.
- Startup latency:
  - pll_locked first sampled high at edge N, with rst_n high and locked stable, gives running=1 after edge N+LOCK_WAIT+2.
  - The first de and frame_start follow after edge N+LOCK_WAIT+3.
- Lookahead requests issued in SETTLE are not required; the first line may have fewer than REQ_LEAD lead cycles only when REQ_LEAD>0. Consumers tolerate this by design.
- Reset mid-frame overrides all states; the restart again waits the full LOCK_WAIT.

Test Plan:
- Reset held 10 cycles with pll_locked=1 → all outputs at reset values, running=0 throughout.
- rst_n=1, pll_locked rises at edge N, LOCK_WAIT=16 → running high after N+18, first de/frame_start after N+19, pix_x=0, pix_y=0.
- Free-run one line →
  - hs period 1650 cycles, active width 40.
  - hs leading edge 1390 cycles after de rise.
  - de high 1280 contiguous cycles; pix_x counts 0..1279.
- Free-run two frames →
  - frame_start period 1,237,500 cycles; 720 de lines per frame.
  - vs width 8250 cycles, starting 725 lines after frame_start's line.
  - pix_y 0..719.
- REQ_LEAD=2 → every de rise is preceded 2 cycles by a pix_req rise; the frame's first pix_req occurs at line 749, h_cnt 1648; per line, pix_req count = 1280.
- pll_locked dropped mid-active line (pix_x=500) → outputs at reset values within 3 edges; relock → full LOCK_WAIT, then restart at (0,0). Repeat the same mid-frame drop with rst_n pulsed instead of pll_locked → identical restart.
